// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_pkg
//  Description : Parameters shared by the 3x3 box-filter processing block,
//                its pixel feeder and the result collector, plus the layout
//                of one collected result.
//  Revision    : 1.0 - initial release
// ============================================================================
package filter_pkg;

    localparam int RESULT_WIDTH = 8;    // width of a filter result
    localparam int IMG_HEIGHT   = 480;  // rows per column strip
    localparam int ROW_W        = 10;   // row-index width
    localparam int PIPE_DEPTH   = 3;    // enables from bottom-row load to result
    localparam int FIFO_DEPTH   = 16;   // collector FIFO entries

    // One collected result: pixel value, window-centre row, end-of-strip flag.
    typedef struct packed {
        logic [RESULT_WIDTH-1:0] data;
        logic [ROW_W-1:0]        row;
        logic                    last;
    } result_entry_t;

    // Row counter step that wraps from the last row of a strip back to 0.
    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row,
                                                  input int               height);
        logic [ROW_W-1:0] last_row;
        last_row = ROW_W'(height - 1);
        return (row == last_row) ? '0 : row + ROW_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with occupancy
//                count. Simultaneous push and pop are accepted, including a
//                push while full when a pop frees the slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16            // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head of the queue is presented directly; zero while nothing is stored.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : filter_result_collector
//  Description : Follows the box filter's enable cadence, keeps only results
//                from windows lying fully inside one column strip, tags them
//                with centre row and end-of-strip flag, buffers them and
//                streams them out over valid/ready. Raises stall toward the
//                pixel feeder before the buffer can overflow.
//                Reset is asserted asynchronously; its source releases it
//                synchronously to clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_result_collector
    import filter_pkg::RESULT_WIDTH;
    import filter_pkg::ROW_W;
    import filter_pkg::result_entry_t;
    import filter_pkg::next_row;
#(
    parameter int IMG_HEIGHT = filter_pkg::IMG_HEIGHT,  // >= 3
    parameter int PIPE_DEPTH = filter_pkg::PIPE_DEPTH,  // >= 1
    parameter int FIFO_DEPTH = filter_pkg::FIFO_DEPTH   // power of 2, >= 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [RESULT_WIDTH-1:0] filter_output,
    output logic                    stall,
    output logic [RESULT_WIDTH-1:0] m_data,
    output logic [ROW_W-1:0]        m_row,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    overflow
);

    localparam int ENCNT_W = $clog2(PIPE_DEPTH + 1);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = $bits(result_entry_t);

    localparam logic [ENCNT_W-1:0] EN_FULL  = ENCNT_W'(PIPE_DEPTH);
    localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0]   MIN_ROW  = ROW_W'(2);
    localparam logic [COUNT_W-1:0] STALL_AT = COUNT_W'(FIFO_DEPTH - 2);

    logic [ENCNT_W-1:0] en_cnt;
    logic [ROW_W-1:0]   in_row;
    logic [ROW_W-1:0]   row_tag [PIPE_DEPTH];

    logic               en_d;
    logic               win_ok;
    logic [ROW_W-1:0]   win_row;

    result_entry_t      push_entry;
    result_entry_t      pop_entry;
    logic [ENTRY_W-1:0] pop_bits;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [COUNT_W-1:0] count;

    // Enable accounting: pipeline fill level, input row and row-tag delay line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_cnt <= '0;
            in_row <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                row_tag[i] <= '0;
            end
        end else if (enable) begin
            if (en_cnt != EN_FULL) begin
                en_cnt <= en_cnt + ENCNT_W'(1);
            end
            in_row     <= next_row(in_row, IMG_HEIGHT);
            row_tag[0] <= in_row;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                row_tag[i] <= row_tag[i-1];
            end
        end
    end

    // Capture, at each enable, the bottom row of the window whose result the
    // filter registers on this edge; the oldest tag (before the shift) is
    // the row loaded PIPE_DEPTH enables earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_d    <= 1'b0;
            win_ok  <= 1'b0;
            win_row <= '0;
        end else begin
            en_d <= enable;
            if (enable) begin
                win_ok  <= (en_cnt == EN_FULL) && (row_tag[PIPE_DEPTH-1] >= MIN_ROW);
                win_row <= row_tag[PIPE_DEPTH-1];
            end
        end
    end

    // Result is valid one cycle after the enable edge; row reported is the
    // window centre, one above the bottom row.
    always_comb begin
        push_entry      = '0;
        push_entry.data = filter_output;
        push_entry.row  = win_row - ROW_W'(1);
        push_entry.last = (win_row == LAST_ROW);
    end

    assign push = en_d && win_ok;
    assign pop  = m_valid && m_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_bits),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

    assign pop_entry = result_entry_t'(pop_bits);
    assign m_valid   = !fifo_empty;
    assign m_data    = pop_entry.data;
    assign m_row     = pop_entry.row;
    assign m_last    = pop_entry.last;

    // Two free slots remain when stall rises: one for a push already in
    // flight behind the last honoured enable, one as margin.
    assign stall = (count >= STALL_AT);

    // Sticky record of any result lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_result_collector
//  Description : Directed bench for filter_result_collector with a 5-row
//                strip and a 4-entry FIFO. A behavioural processing block
//                returns 10*n after enable n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_result_collector;

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] row;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] filter_output;
    logic       stall;
    logic [7:0] m_data;
    logic [9:0] m_row;
    logic       m_last;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       overflow;

    int         checks = 0;
    int         failures = 0;
    int         max_count = 0;
    exp_t       got[$];
    exp_t       strip_tab[6];
    logic [7:0] fn;

    filter_result_collector #(
        .IMG_HEIGHT (5),
        .PIPE_DEPTH (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .filter_output (filter_output),
        .stall         (stall),
        .m_data        (m_data),
        .m_row         (m_row),
        .m_last        (m_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Processing-block stand-in: registered result 10*n after enable n.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_output <= 8'd0;
            fn            <= 8'd0;
        end else if (enable) begin
            filter_output <= 8'(fn * 8'd10);
            fn            <= fn + 8'd1;
        end
    end

    // Output monitor and occupancy tracker, sampled between active edges.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                got.push_back({m_data, m_row, m_last});
            end
            if (int'(dut.count) > max_count) begin
                max_count = int'(dut.count);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        got.delete();
        max_count = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Issue num enables; with honour set, hold enable low while stall is high.
    task automatic feed(input int num, input bit honour, input int max_cycles);
        int sent = 0;
        int cyc  = 0;
        while (sent < num && cyc < max_cycles) begin
            if (honour && stall) begin
                enable = 1'b0;
            end else begin
                enable = 1'b1;
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        enable = 1'b0;
        if (sent < num) check("feed_timeout", sent, num);
    endtask

    task automatic wait_outputs(input int n, input int max_cycles);
        int cyc = 0;
        while (got.size() < n && cyc < max_cycles) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("out_count", got.size(), n);
    endtask

    task automatic compare_stream(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) begin
                check($sformatf("%s_data%0d", nm, i), got[i].data, strip_tab[i].data);
                check($sformatf("%s_row%0d",  nm, i), got[i].row,  strip_tab[i].row);
                check($sformatf("%s_last%0d", nm, i), got[i].last, strip_tab[i].last);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two strips of 5 rows: bottom rows 2,3,4 of each strip yield centres 1,2,3.
        strip_tab[0] = '{data: 8'd50,  row: 10'd1, last: 1'b0};
        strip_tab[1] = '{data: 8'd60,  row: 10'd2, last: 1'b0};
        strip_tab[2] = '{data: 8'd70,  row: 10'd3, last: 1'b1};
        strip_tab[3] = '{data: 8'd100, row: 10'd1, last: 1'b0};
        strip_tab[4] = '{data: 8'd110, row: 10'd2, last: 1'b0};
        strip_tab[5] = '{data: 8'd120, row: 10'd3, last: 1'b1};

        // Reset state.
        do_reset();
        check("rst_m_valid",  m_valid,  0);
        check("rst_m_data",   m_data,   0);
        check("rst_m_row",    m_row,    0);
        check("rst_m_last",   m_last,   0);
        check("rst_stall",    stall,    0);
        check("rst_overflow", overflow, 0);

        // Two strips plus three flush enables, always ready.
        m_ready = 1'b1;
        feed(13, 1'b1, 200);
        wait_outputs(6, 50);
        repeat (5) @(posedge clk);
        #1;
        check("stream_total", got.size(), 6);
        compare_stream("stream", 6);
        check("stream_overflow", overflow, 0);

        // Back-pressure with a feeder that honours stall.
        do_reset();
        fork
            feed(13, 1'b1, 300);
            begin
                repeat (25) @(posedge clk);
                #1;
                check("bp_stall",     stall,     1);
                check("bp_max_count", max_count, 3);
                check("bp_overflow",  overflow,  0);
                check("bp_head",      m_data,    50);
                m_ready = 1'b1;
            end
        join
        wait_outputs(6, 60);
        compare_stream("bp", 6);
        check("bp_overflow_end", overflow, 0);
        check("bp_max_final",    max_count, 3);

        // Feeder ignores stall with the FIFO held full.
        do_reset();
        feed(13, 1'b0, 100);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_set",  overflow, 1);
        check("ovf_head", m_data,   50);
        m_ready = 1'b1;
        wait_outputs(4, 20);
        compare_stream("ovf", 4);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_drained", m_valid,  0);
        check("ovf_sticky",  overflow, 1);

        // Simultaneous push and pop at count 2.
        do_reset();
        feed(7, 1'b0, 50);
        repeat (2) @(posedge clk);
        #1;
        check("pp_count_before", dut.count, 2);
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable  = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("pp_count_after", dut.count, 2);
        check("pp_head_data",   m_data,    60);
        check("pp_head_row",    m_row,     2);
        m_ready = 1'b1;
        wait_outputs(3, 20);
        compare_stream("pp", 3);

        // Asynchronous reset mid-strip while output is valid.
        do_reset();
        feed(7, 1'b0, 50);
        repeat (2) @(posedge clk);
        #1;
        check("ar_valid_before", m_valid, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_valid_async", m_valid, 0);
        check("ar_data_async",  m_data,  0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got.delete();
        m_ready = 1'b1;
        feed(5, 1'b0, 50);
        repeat (5) @(posedge clk);
        #1;
        check("ar_no_early", got.size(), 0);
        feed(1, 1'b0, 10);
        wait_outputs(1, 10);
        compare_stream("ar", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
